// File: rtl/uart_pkg.sv
//==============================================================================
// uart_pkg -- shared state encoding and sizing for the UART transmitter slice.
// Rev 1.0
//==============================================================================
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
//==============================================================================
// uart_bit_timer -- bit-cell counter; cell_done pulses on the last cycle of a cell.
// Rev 1.0
//==============================================================================
`default_nettype none

module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic cell_done
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cell_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = clear ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_unit.sv
//==============================================================================
// uart_tx_unit -- 8N1 UART transmitter popping bytes from a one-word buffer;
// defining UART_TX_PARITY_EN inserts an even-parity bit after the data bits.  Rev 1.0
//==============================================================================
`default_nettype none

module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 empty,
  input  logic [DATA_BITS-1:0] r_data,
  output logic                 re,
  output logic                 tx,
  output logic                 busy
);

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 cell_done;
  logic                 timer_clear;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  // Gating with reset keeps the buffer untouched while reset is held.
  assign re   = reset & (state_q == IDLE) & ~empty;
  assign tx   = tx_q;
  assign busy = busy_q;

  // Counter sits at zero in IDLE, so every cell starts from a clean count.
  assign timer_clear = (state_q == IDLE) | cell_done;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .cell_done (cell_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (re) begin
            shift_q  <= r_data;
            idx_q    <= '0;
            state_q  <= START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^r_data;
`endif
          end
        end
        START: begin
          if (cell_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (cell_done) begin
            if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              // Next bit is presented from bit 1 as the register shifts.
              idx_q   <= idx_q + IDX_W'(1);
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cell_done) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (cell_done) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
